// File: rtl/i2s_sample_fifo.sv
// ---------------------------------------------------------------------------
// i2s_sample_fifo
//
// Stereo sample buffer in front of the I2S transmitter. The host or DMA side
// writes packed {left, right} words through a valid/ready handshake. The
// transmitter reads them first-word-fall-through on out_data/out_valid/
// out_ready. Fill level, a low-water warning and a sticky underrun flag are
// provided so software can keep the stream fed.
//
// Optional feature (macro I2S_FIFO_ZERO_FILL_EN): while streaming (RUN) and
// empty, the FIFO offers a zero (silence) word with out_valid=1. That word
// is consumed without moving the pointers or the level.
//
// Ports:
//   clk           single rising-edge clock, shared with the transmitter
//   rst_n         asynchronous active-low reset
//   clear         synchronous flush: empties FIFO, clears underrun, -> IDLE
//   wr_data       stereo sample {left, right}, left in the upper half
//   wr_valid      write request
//   wr_ready      FIFO can accept (= !full)
//   out_data      head-of-FIFO sample (0 while empty)
//   out_valid     out_data valid
//   out_ready     consumer ready
//   level         number of stored words, 0..2**DEPTH_LOG2
//   low_water     level <= LOW_WATER
//   underrun      sticky underrun flag
//   underrun_clr  write-1 pulse clearing underrun
// ---------------------------------------------------------------------------
module i2s_sample_fifo #(
  parameter int WORD_LENGTH = 16,
  parameter int DEPTH_LOG2  = 3,
  parameter int LOW_WATER   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [2*WORD_LENGTH-1:0]   wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [2*WORD_LENGTH-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DEPTH_LOG2:0]        level,
  output logic                       low_water,
  output logic                       underrun,
  input  logic                       underrun_clr
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  logic [2*WORD_LENGTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]    wr_ptr;
  logic [DEPTH_LOG2-1:0]    rd_ptr;
  state_t                   state;
  state_t                   state_nxt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic underrun_set;

  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  assign wr_ready  = !full;
  assign low_water = (int'(level) <= LOW_WATER);

`ifdef I2S_FIFO_ZERO_FILL_EN
  // Silence is offered only once streaming has started.
  assign out_valid = !empty || (state == RUN);
`else
  assign out_valid = !empty;
`endif
  assign out_data = empty ? '0 : mem[rd_ptr];

  // clear overrides both sides of the FIFO in the same cycle.
  assign push = wr_valid && wr_ready && !clear;
  // Only a real word moves pointers; a zero-fill transfer is not a pop.
  assign pop  = out_valid && out_ready && !empty && !clear;

  // The consumer asking for data while empty is an underrun once streaming.
  // With zero fill this is exactly the zero-word transfer condition.
  assign underrun_set = (state == RUN) && out_ready && empty;

  always_comb begin
    state_nxt = state;
    if (clear)
      state_nxt = IDLE;
    else if (state == IDLE && pop)
      state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      underrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        underrun <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop)
          rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        if (push && !pop)
          level <= level + (DEPTH_LOG2+1)'(1);
        else if (pop && !push)
          level <= level - (DEPTH_LOG2+1)'(1);
        // A new underrun beats a simultaneous clear pulse.
        if (underrun_set)
          underrun <= 1'b1;
        else if (underrun_clr)
          underrun <= 1'b0;
      end
    end
  end

  // Storage is data only; it is never reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_i2s_sample_fifo.sv
module tb_i2s_sample_fifo;

  localparam int DEPTH = 8;
  localparam int LW    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        low_water;
  logic        underrun;
  logic        underrun_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of stored words plus streaming/underrun flags.
  logic [31:0] q[$];
  bit          m_run;
  bit          m_ur;

  i2s_sample_fifo #(.WORD_LENGTH(16), .DEPTH_LOG2(3), .LOW_WATER(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .low_water(low_water), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_valid();
    bit zf;
`ifdef I2S_FIFO_ZERO_FILL_EN
    zf = m_run;
`else
    zf = 1'b0;
`endif
    return (q.size() != 0) || zf;
  endfunction

  function automatic logic [31:0] m_data();
    return (q.size() != 0) ? q[0] : 32'h0;
  endfunction

  task automatic drive(input bit wv, input logic [31:0] wd, input bit ordy,
                       input bit clr, input bit uclr);
    wr_valid = wv; wr_data = wd; out_ready = ordy; clear = clr; underrun_clr = uclr;
  endtask

  // One clock: check all outputs against the model mid-cycle, then apply
  // the edge to the model.
  task automatic tick();
    bit          accept, xfer, was_run, was_empty;
    logic [31:0] wd;
    @(negedge clk);
    chk("level",     64'(level),     64'(q.size()));
    chk("wr_ready",  64'(wr_ready),  64'(q.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(m_valid()));
    chk("out_data",  64'(out_data),  64'(m_data()));
    chk("low_water", 64'(low_water), 64'(q.size() <= LW));
    chk("underrun",  64'(underrun),  64'(m_ur));
    accept    = wr_valid && (q.size() < DEPTH);
    xfer      = m_valid() && out_ready;
    was_run   = m_run;
    was_empty = (q.size() == 0);
    wd        = wr_data;
    @(posedge clk);
    if (clear) begin
      q.delete(); m_run = 0; m_ur = 0;
    end else begin
      if (xfer && !was_empty) begin
        void'(q.pop_front());
        m_run = 1;
      end
      if (was_run && out_ready && was_empty) m_ur = 1;
      else if (underrun_clr) m_ur = 0;
      if (accept) q.push_back(wd);
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0, 0);
    q.delete(); m_run = 0; m_ur = 0;
    #12;
    // Reset state
    chk("rst_wr_ready",  64'(wr_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_low_water", 64'(low_water), 64'd1);
    chk("rst_level",     64'(level),     64'd0);
    chk("rst_underrun",  64'(underrun),  64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IDLE: consumer asking while empty never flags underrun
    drive(0, 32'h0, 1, 0, 0);
    repeat (20) tick();
    chk("idle_underrun", 64'(underrun), 64'd0);

    // Two pushes with consumer stalled
    drive(1, 32'h1111_2222, 0, 0, 0); tick();
    chk("fwft_valid", 64'(out_valid), 64'd1);
    chk("fwft_data",  64'(out_data),  64'h1111_2222);
    drive(1, 32'h3333_4444, 0, 0, 0); tick();
    chk("two_level", 64'(level),     64'd2);
    chk("two_lw",    64'(low_water), 64'd1);
    chk("two_head",  64'(out_data),  64'h1111_2222);

    // Fill to full, then a 9th request is refused
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'hA000_0000 + 32'(i), 0, 0, 0); tick();
    end
    chk("full_level", 64'(level),    64'd8);
    chk("full_ready", 64'(wr_ready), 64'd0);
    drive(1, 32'hDEAD_BEEF, 0, 0, 0); tick();
    chk("ninth_level", 64'(level), 64'd8);
    // Push offered while full and popping: still refused
    drive(1, 32'hDEAD_BEEF, 1, 0, 0); tick();
    chk("full_pop_level", 64'(level), 64'd7);
    drive(0, 32'h0, 1, 0, 0);
    repeat (7) tick();
    chk("drain_level", 64'(level), 64'd0);
    drive(0, 32'h0, 0, 0, 0); tick();

    // Steady state at level 4 with wrap-around
    drive(0, 32'h0, 0, 1, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hB000_0000 + 32'(i), 0, 0, 0); tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom, 1, 0, 0); tick();
      chk("steady_level", 64'(level), 64'd4);
    end
    drive(0, 32'h0, 1, 0, 0);
    repeat (4) tick();
    drive(0, 32'h0, 0, 1, 0); tick();

    // Underrun set and clear rules
    drive(1, 32'h5555_6666, 0, 0, 0); tick();
    drive(0, 32'h0, 1, 0, 0); tick();
    tick();
    chk("ur_set", 64'(underrun), 64'd1);
    drive(0, 32'h0, 0, 0, 1); tick();
    chk("ur_clr", 64'(underrun), 64'd0);
    drive(0, 32'h0, 1, 0, 0); tick();
    drive(0, 32'h0, 1, 0, 1); tick();
    chk("ur_set_wins", 64'(underrun), 64'd1);

    // clear at level 5 with a push presented
    drive(0, 32'h0, 0, 1, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'hC000_0000 + 32'(i), 0, 0, 0); tick();
    end
    drive(1, 32'hFFFF_FFFF, 0, 1, 0); tick();
    chk("clr_level", 64'(level),     64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    drive(0, 32'h0, 1, 0, 0);
    repeat (3) tick();
    chk("clr_idle_ur", 64'(underrun), 64'd0);

`ifdef I2S_FIFO_ZERO_FILL_EN
    // Zero fill while streaming
    drive(1, 32'h0101_0202, 0, 0, 0); tick();
    drive(1, 32'h0303_0404, 0, 0, 0); tick();
    drive(0, 32'h0, 1, 0, 0); tick(); tick();
    chk("zf_valid", 64'(out_valid), 64'd1);
    chk("zf_data",  64'(out_data),  64'd0);
    repeat (3) tick();
    chk("zf_level", 64'(level),    64'd0);
    chk("zf_ur",    64'(underrun), 64'd1);
    drive(1, 32'hAAAA_5555, 1, 0, 0); tick();
    chk("zf_push_data",  64'(out_data), 64'hAAAA_5555);
    chk("zf_push_level", 64'(level),    64'd1);
    drive(0, 32'h0, 0, 1, 0); tick();
`endif

    // Asynchronous reset mid-transfer
    drive(1, 32'h7777_8888, 0, 0, 0); tick(); tick();
    drive(0, 32'h0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level),     64'd0);
    q.delete(); m_run = 0; m_ur = 0;
    drive(0, 32'h0, 0, 0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
